wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
//  Owns the single register-file write port after the WB stage. Arbitrates it between the
//  in-order pipeline writeback (wb_data) and results from the multi-cycle MUL/DIV unit (MDU).
//  Buffers MDU results in a small FIFO and tracks MDU-pending rd in a scoreboard for hazard stalls.
//  Forces a one-cycle pipeline stall when a buffered MDU result starves.
// PARAMETERS
//  XLEN          32  datapath width
//  FIFO_DEPTH    2   MDU result buffer entries (power of two, >=2)
//  STARVE_LIMIT  4   cycles a non-empty FIFO head may wait before a forced drain
// PORTS
//  clk           in   1     rising-edge clock
//  rst_n         in   1     asynchronous, active-low reset
//  wb_reg_write  in   1     pipeline WB wants to write (CTRL_REG_WRITE of MEM/WB)
//  wb_rd         in   5     pipeline destination register
//  wb_data       in   XLEN  pipeline writeback value (output of wb_stage)
//  mdu_issue     in   1     MDU accepted an op this cycle
//  mdu_issue_rd  in   5     rd of the issued MDU op
//  mdu_valid     in   1     MDU presents a result
//  mdu_rd        in   5     result rd
//  mdu_data      in   XLEN  result value
//  mdu_ready     out  1     FIFO can accept a result (= !full)
//  rf_we         out  1     register-file write enable
//  rf_rd         out  5     register-file write address
//  rf_wdata      out  XLEN  register-file write data
//  wb_stall_req  out  1     pipeline must hold MEM/WB this cycle
//  pending_mask  out  32    bit i = MDU result for xi outstanding
// BEHAVIOUR
//  Reset (rst_n=0, async): FIFO empty, pointers and count 0, starve counter 0,
//   wb_stall_req=0, pending_mask=0. rf_we is forced to 0 while rst_n=0. mdu_ready=1.
//  Effective requests: pipe_req = wb_reg_write && wb_rd!=0 && !wb_stall_req.
//   fifo_req = FIFO not empty.
//  Grant (combinational, same cycle, 0 latency):
//   - pipe_req wins. rf_we=1, rf_rd=wb_rd, rf_wdata=wb_data.
//   - Otherwise fifo_req: rf_we=1, rf_rd/rf_wdata = FIFO head. The head pops at the clock edge.
//   - Otherwise rf_we=0. rf_rd and rf_wdata are 0.
//  FIFO push: on mdu_valid && mdu_ready. A result with mdu_rd==0 is accepted but not stored,
//   so it never writes. There is no same-cycle bypass: a pushed result can be granted no
//   earlier than the next cycle. With the FIFO full, mdu_ready=0 even if a pop occurs in the
//   same cycle. Push and pop in the same cycle are both performed and count is unchanged.
//   Pointers wrap modulo FIFO_DEPTH.
//  Starvation (registered): the starve counter increments each cycle with fifo_req && pipe_req.
//   It clears on any FIFO pop or when the FIFO is empty.
//   When the counter reaches STARVE_LIMIT-1 while still denied, wb_stall_req=1 in the next cycle.
//   In that cycle the FIFO head is granted regardless of wb_reg_write, and the counter clears.
//   wb_stall_req then deasserts, so it is high for exactly 1 cycle per event.
//   The pipeline holds wb_* stable, and that write completes in the following cycle.
//  Scoreboard: mdu_issue && mdu_issue_rd!=0 sets pending_mask[mdu_issue_rd] at the clock edge.
//   A FIFO pop clears the bit of the head rd. Set and clear of the same bit in the same cycle:
//   set wins. pending_mask[0] is always 0.
//   The hazard unit stalls on pending_mask. The arbiter does not block a pipeline write to a
//   pending rd.
//  Reset mid-operation: buffered results and pending bits are discarded, with no write issued.
// TESTING
//  1 Pipeline only: wb_reg_write=1, rd=5, data=DEADBEEF, FIFO empty
//    -> same cycle rf_we=1, rf_rd=5, rf_wdata=DEADBEEF. rd=0 -> rf_we=0.
//  2 MDU only: issue rd=7 -> pending_mask[7]=1. Result CAFEBABE with the pipeline idle
//    -> written the next cycle. pending_mask[7]=0 after the pop.
//  3 Contention: MDU result rd=3 buffered, pipeline writes every cycle
//    -> pipeline granted 4 cycles, then wb_stall_req=1 for 1 cycle with rf_rd=3,
//    -> then the held pipeline write lands.
//  4 Full FIFO: 2 results buffered, pipeline busy -> mdu_ready=0.
//    After the forced drain -> mdu_ready=1, and a push plus a pop in one cycle keeps count=1.
//  5 Scoreboard race: mdu_issue rd=9 in the same cycle as a pop of an older rd=9
//    -> pending_mask[9] stays 1.
//  6 Async reset with 2 buffered entries and pending bits
//    -> immediately rf_we=0, pending_mask=0, mdu_ready=1. No stale write after release.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered MUL/DIV results,
// with starvation-forced drain and an outstanding-rd scoreboard.
module wb_write_arbiter #(
   parameter int unsigned Xlen        = 32,
   parameter int unsigned FifoDepth   = 2,
   parameter int unsigned StarveLimit = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            wb_reg_write_i,
   input  logic [4:0]      wb_rd_i,
   input  logic [Xlen-1:0] wb_data_i,
   input  logic            mdu_issue_i,
   input  logic [4:0]      mdu_issue_rd_i,
   input  logic            mdu_valid_i,
   input  logic [4:0]      mdu_rd_i,
   input  logic [Xlen-1:0] mdu_data_i,
   output logic            mdu_ready_o,
   output logic            rf_we_o,
   output logic [4:0]      rf_rd_o,
   output logic [Xlen-1:0] rf_wdata_o,
   output logic            wb_stall_req_o,
   output logic [31:0]     pending_mask_o
);

   localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned StW  = $clog2(StarveLimit) + 1;

   logic [4:0]      rd_q   [FifoDepth];
   logic [Xlen-1:0] data_q [FifoDepth];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic [StW-1:0]  starve_q, starve_d;
   logic            stall_q, stall_d;
   logic [31:0]     pending_q, pending_d;

   logic full, empty, pipe_req, fifo_req, gnt_pipe, gnt_fifo, push, pop;
   logic [4:0]      head_rd;
   logic [Xlen-1:0] head_data;

   assign full      = (count_q == CntW'(FifoDepth));
   assign empty     = (count_q == '0);
   assign head_rd   = rd_q[rd_ptr_q];
   assign head_data = data_q[rd_ptr_q];

   // During a forced-drain cycle the pipeline request is masked so the head wins.
   assign pipe_req  = wb_reg_write_i && (wb_rd_i != 5'd0) && !stall_q;
   assign fifo_req  = !empty;
   assign gnt_pipe  = pipe_req;
   assign gnt_fifo  = fifo_req && !pipe_req;
   assign pop       = gnt_fifo;
   // rd==0 results are acknowledged but dropped, so they never reach the write port.
   assign push      = mdu_valid_i && !full && (mdu_rd_i != 5'd0);

   always_comb begin
      rf_we_o    = 1'b0;
      rf_rd_o    = 5'd0;
      rf_wdata_o = '0;
      if (rst_ni) begin
         if (gnt_pipe) begin
            rf_we_o    = 1'b1;
            rf_rd_o    = wb_rd_i;
            rf_wdata_o = wb_data_i;
         end else if (gnt_fifo) begin
            rf_we_o    = 1'b1;
            rf_rd_o    = head_rd;
            rf_wdata_o = head_data;
         end
      end
   end

   assign mdu_ready_o    = !full;
   assign wb_stall_req_o = stall_q;
   assign pending_mask_o = pending_q;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_comb begin
      starve_d = '0;
      stall_d  = 1'b0;
      if (fifo_req && !pop && pipe_req) begin
         if (starve_q == StW'(StarveLimit - 1)) begin
            stall_d = 1'b1;
         end else begin
            starve_d = starve_q + StW'(1);
         end
      end
   end

   // Set wins over clear so a re-issue of the same rd stays tracked.
   always_comb begin
      pending_d = pending_q;
      if (pop) begin
         pending_d[head_rd] = 1'b0;
      end
      if (mdu_issue_i && (mdu_issue_rd_i != 5'd0)) begin
         pending_d[mdu_issue_rd_i] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         starve_q  <= '0;
         stall_q   <= 1'b0;
         pending_q <= '0;
         for (int i = 0; i < int'(FifoDepth); i++) begin
            rd_q[i]   <= 5'd0;
            data_q[i] <= '0;
         end
      end else begin
         count_q   <= count_d;
         starve_q  <= starve_d;
         stall_q   <= stall_d;
         pending_q <= pending_d;
         if (push) begin
            rd_q[wr_ptr_q]   <= mdu_rd_i;
            data_q[wr_ptr_q] <= mdu_data_i;
            wr_ptr_q         <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
      end
   end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: pipeline-only, MDU-only, contention,
// full FIFO, scoreboard race and mid-operation async reset.
module tb_wb_write_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        wb_reg_write_i;
   logic [4:0]  wb_rd_i;
   logic [31:0] wb_data_i;
   logic        mdu_issue_i;
   logic [4:0]  mdu_issue_rd_i;
   logic        mdu_valid_i;
   logic [4:0]  mdu_rd_i;
   logic [31:0] mdu_data_i;
   logic        mdu_ready_o;
   logic        rf_we_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_wdata_o;
   logic        wb_stall_req_o;
   logic [31:0] pending_mask_o;

   int n_vec = 0;
   int n_err = 0;

   wb_write_arbiter #(
      .Xlen        (32),
      .FifoDepth   (2),
      .StarveLimit (4)
   ) u_dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .wb_reg_write_i (wb_reg_write_i),
      .wb_rd_i        (wb_rd_i),
      .wb_data_i      (wb_data_i),
      .mdu_issue_i    (mdu_issue_i),
      .mdu_issue_rd_i (mdu_issue_rd_i),
      .mdu_valid_i    (mdu_valid_i),
      .mdu_rd_i       (mdu_rd_i),
      .mdu_data_i     (mdu_data_i),
      .mdu_ready_o    (mdu_ready_o),
      .rf_we_o        (rf_we_o),
      .rf_rd_o        (rf_rd_o),
      .rf_wdata_o     (rf_wdata_o),
      .wb_stall_req_o (wb_stall_req_o),
      .pending_mask_o (pending_mask_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      wb_reg_write_i = 1'b0;
      wb_rd_i        = 5'd0;
      wb_data_i      = 32'd0;
      mdu_issue_i    = 1'b0;
      mdu_issue_rd_i = 5'd0;
      mdu_valid_i    = 1'b0;
      mdu_rd_i       = 5'd0;
      mdu_data_i     = 32'd0;
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pipe(input logic [4:0] rd, input logic [31:0] data);
      wb_reg_write_i = 1'b1;
      wb_rd_i        = rd;
      wb_data_i      = data;
   endtask

   task automatic mdu_push(input logic [4:0] rd, input logic [31:0] data);
      mdu_valid_i = 1'b1;
      mdu_rd_i    = rd;
      mdu_data_i  = data;
   endtask

   task automatic issue(input logic [4:0] rd);
      mdu_issue_i    = 1'b1;
      mdu_issue_rd_i = rd;
   endtask

   initial begin
      rst_ni = 1'b0;
      idle();
      #12;
      check_eq("rst_we",      32'(rf_we_o), 32'd0);
      check_eq("rst_ready",   32'(mdu_ready_o), 32'd1);
      check_eq("rst_stall",   32'(wb_stall_req_o), 32'd0);
      check_eq("rst_pending", pending_mask_o, 32'd0);
      cyc();
      rst_ni = 1'b1;

      // Pipeline only
      cyc(); pipe(5'd5, 32'hDEADBEEF); #2;
      check_eq("t1_we",    32'(rf_we_o), 32'd1);
      check_eq("t1_rd",    32'(rf_rd_o), 32'd5);
      check_eq("t1_data",  rf_wdata_o, 32'hDEADBEEF);
      cyc(); wb_rd_i = 5'd0; #2;
      check_eq("t1_rd0_we",   32'(rf_we_o), 32'd0);
      check_eq("t1_rd0_data", rf_wdata_o, 32'd0);

      // MDU only
      cyc(); idle(); issue(5'd7); #2;
      check_eq("t2_pend_pre", pending_mask_o, 32'd0);
      cyc(); idle(); mdu_push(5'd7, 32'hCAFEBABE); #2;
      check_eq("t2_pend_set", pending_mask_o, 32'h0000_0080);
      check_eq("t2_nobypass", 32'(rf_we_o), 32'd0);
      cyc(); idle(); #2;
      check_eq("t2_we",    32'(rf_we_o), 32'd1);
      check_eq("t2_rd",    32'(rf_rd_o), 32'd7);
      check_eq("t2_data",  rf_wdata_o, 32'hCAFEBABE);
      cyc(); #2;
      check_eq("t2_pend_clr", pending_mask_o, 32'd0);
      check_eq("t2_we_idle",  32'(rf_we_o), 32'd0);

      // Contention: head waits 4 granted pipeline cycles, then one forced drain
      cyc(); pipe(5'd10, 32'hA0); mdu_push(5'd3, 32'h33); #2;
      check_eq("t3_push_rd", 32'(rf_rd_o), 32'd10);
      for (int i = 0; i < 4; i++) begin
         cyc(); mdu_valid_i = 1'b0; #2;
         check_eq("t3_pipe_rd",  32'(rf_rd_o), 32'd10);
         check_eq("t3_no_stall", 32'(wb_stall_req_o), 32'd0);
      end
      cyc(); #2;
      check_eq("t3_stall",    32'(wb_stall_req_o), 32'd1);
      check_eq("t3_drain_rd", 32'(rf_rd_o), 32'd3);
      check_eq("t3_drain_d",  rf_wdata_o, 32'h33);
      cyc(); #2;
      check_eq("t3_unstall",  32'(wb_stall_req_o), 32'd0);
      check_eq("t3_held_rd",  32'(rf_rd_o), 32'd10);
      check_eq("t3_held_d",   rf_wdata_o, 32'hA0);
      cyc(); idle(); #2;

      // Full FIFO
      cyc(); pipe(5'd10, 32'hB0); mdu_push(5'd1, 32'h11); #2;
      check_eq("t4_ready_a", 32'(mdu_ready_o), 32'd1);
      cyc(); mdu_push(5'd2, 32'h22); #2;
      check_eq("t4_ready_b", 32'(mdu_ready_o), 32'd1);
      cyc(); mdu_valid_i = 1'b0; #2;
      check_eq("t4_full", 32'(mdu_ready_o), 32'd0);
      cyc(); #2;
      cyc(); #2;
      check_eq("t4_pre_stall", 32'(wb_stall_req_o), 32'd0);
      cyc(); #2;
      check_eq("t4_stall",     32'(wb_stall_req_o), 32'd1);
      check_eq("t4_drain_rd",  32'(rf_rd_o), 32'd1);
      check_eq("t4_full_pop",  32'(mdu_ready_o), 32'd0);
      cyc(); idle(); mdu_push(5'd4, 32'h44); #2;
      check_eq("t4_ready_c", 32'(mdu_ready_o), 32'd1);
      check_eq("t4_head2",   32'(rf_rd_o), 32'd2);
      cyc(); idle(); #2;
      check_eq("t4_ready_d", 32'(mdu_ready_o), 32'd1);
      check_eq("t4_head4",   32'(rf_rd_o), 32'd4);
      check_eq("t4_data4",   rf_wdata_o, 32'h44);
      cyc(); #2;
      check_eq("t4_empty",   32'(rf_we_o), 32'd0);

      // Scoreboard race: re-issue of rd 9 coincides with pop of older rd 9
      cyc(); idle(); issue(5'd9); #2;
      cyc(); idle(); mdu_push(5'd9, 32'h99); #2;
      cyc(); idle(); issue(5'd9); #2;
      check_eq("t5_pop_rd", 32'(rf_rd_o), 32'd9);
      check_eq("t5_pend_a", pending_mask_o, 32'h0000_0200);
      cyc(); idle(); #2;
      check_eq("t5_pend_b", pending_mask_o, 32'h0000_0200);

      // Async reset with two buffered entries
      cyc(); pipe(5'd10, 32'hC0); issue(5'd12); mdu_push(5'd12, 32'hC); #2;
      cyc(); issue(5'd13); mdu_push(5'd13, 32'hD); #2;
      cyc(); mdu_issue_i = 1'b0; mdu_valid_i = 1'b0; #2;
      check_eq("t6_full",    32'(mdu_ready_o), 32'd0);
      check_eq("t6_pend",    pending_mask_o, 32'h0000_3200);
      #1 rst_ni = 1'b0;
      #1;
      check_eq("t6_rst_we",    32'(rf_we_o), 32'd0);
      check_eq("t6_rst_pend",  pending_mask_o, 32'd0);
      check_eq("t6_rst_ready", 32'(mdu_ready_o), 32'd1);
      cyc(); idle(); rst_ni = 1'b1; #2;
      check_eq("t6_post_we_a", 32'(rf_we_o), 32'd0);
      cyc(); #2;
      check_eq("t6_post_we_b", 32'(rf_we_o), 32'd0);
      check_eq("t6_post_pend", pending_mask_o, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
